instr_controller: RTL and testbench

Instruction register, decoder and control FSM for the Simple RISC Machine. Sits directly upstream of the datapath and drives every datapath control input: register-file read/write selects, A/B/C/status load enables, shifter, ALU and mux selects. It also supplies the sign-extended immediates. It executes one instruction per `s` pulse and reports idle through `w`.

---
 rtl/instr_controller_pkg.sv | 102 ++++++++++
 rtl/instr_decoder.sv | 18 +
 rtl/instr_controller.sv | 110 +++++++++++
 tb/tb_instr_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_controller_pkg.sv
// Shared types and constants for the instruction controller.
// INSTR_CONTROLLER_ILLEGAL_TRAP_EN adds the err flag to the control bundle.
package instr_controller_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_WRITE_IMM,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [1:0]  sh;
        logic [2:0]  rm;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } decoded_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
        logic       err;
`endif
    } ctrl_t;

    // Moore control word for a given state; everything not driven stays 0.
    function automatic ctrl_t ctrl_for(input state_t st, input decoded_t d);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT:      c.w = 1'b1;
            S_GET_A: begin
                c.readnum = d.rn;
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = d.rm;
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                c.shift  = d.sh;
                c.asel   = (d.opcode == OPC_MOV);
                c.alu_op = (d.opcode == OPC_ALU) ? d.op : 2'b00;
                if (d.opcode == OPC_ALU && d.op == OP_CMP) c.loads = 1'b1;
                else                                       c.loadc = 1'b1;
            end
            S_WRITE_REG: begin
                c.writenum = d.rd;
                c.vsel     = VSEL_C;
                c.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                c.writenum = d.rn;
                c.vsel     = VSEL_IMM8;
                c.write    = 1'b1;
            end
            S_HALT: begin
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
                c.err = 1'b1;
`endif
            end
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR field extraction and immediate sign extension.
module instr_decoder
    import instr_controller_pkg::*;
(
    input  logic [15:0] ir,
    output decoded_t    dec
);

    assign dec.opcode = ir[15:13];
    assign dec.op     = ir[12:11];
    assign dec.rn     = ir[10:8];
    assign dec.rd     = ir[7:5];
    assign dec.sh     = ir[4:3];
    assign dec.rm     = ir[2:0];
    assign dec.sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign dec.sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/instr_controller.sv
// Instruction register, decoder and control FSM for the Simple RISC Machine.
// Define INSTR_CONTROLLER_ILLEGAL_TRAP_EN to trap illegal encodings in HALT with err.
module instr_controller
    import instr_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
    ,
    output logic        err
`endif
);

    state_t     state;
    state_t     state_next;
    logic [15:0] ir;
    decoded_t   dec;
    ctrl_t      ctrl;

    instr_decoder u_decoder (
        .ir  (ir),
        .dec (dec)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:   if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (dec.opcode == OPC_MOV && dec.op == OP_MOV_IMM)
                    state_next = S_WRITE_IMM;
                else if (dec.opcode == OPC_MOV && dec.op == OP_MOV_REG)
                    state_next = S_GET_B;
                else if (dec.opcode == OPC_ALU) begin
                    case (dec.op)
                        OP_ADD, OP_CMP, OP_AND: state_next = S_GET_A;
                        OP_MVN:                 state_next = S_GET_B;
                        default:                state_next = S_WAIT;
                    endcase
                end else begin
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
                    state_next = S_HALT;
`else
                    state_next = S_WAIT;
`endif
                end
            end
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_EXEC;
            S_EXEC:      state_next = (dec.opcode == OPC_ALU && dec.op == OP_CMP) ? S_WAIT
                                                                                   : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            S_WRITE_IMM: state_next = S_WAIT;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_WAIT;
        endcase
    end

    // Outputs are registered from the next state. IR can only change when the
    // next state is WAIT or DECODE, whose control words do not depend on IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            ctrl  <= ctrl_for(S_WAIT, '0);
        end else begin
            state <= state_next;
            if (load && state == S_WAIT) ir <= in;
            ctrl  <= ctrl_for(state_next, dec);
        end
    end

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign vsel     = ctrl.vsel;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign shift    = ctrl.shift;
    assign ALUop    = ctrl.alu_op;
    assign sximm8   = dec.sximm8;
    assign sximm5   = dec.sximm5;
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
    assign err      = ctrl.err;
`endif

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller: per-cycle expected control words in a queue.
// Build with INSTR_CONTROLLER_ILLEGAL_TRAP_EN to cover the HALT trap.
module tb_instr_controller;

    localparam int W = 55;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    instr_controller dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
        ,
        .err      (err_o)
`endif
    );

`ifndef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
    assign err_o = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Packed layout: {err, w, readnum, writenum, write, vsel, {loada,loadb,loadc,loads},
    //                 asel, bsel, shift, ALUop, sximm8, sximm5}
    function automatic logic [W-1:0] cv(input logic w_e, input logic [2:0] rn_e,
                                        input logic [2:0] wn_e, input logic wr_e,
                                        input logic [3:0] vs_e, input logic [3:0] ld_e,
                                        input logic as_e, input logic [1:0] sh_e,
                                        input logic [1:0] al_e, input logic err_e,
                                        input logic [15:0] s8, input logic [15:0] s5);
        return {err_e, w_e, rn_e, wn_e, wr_e, vs_e, ld_e, as_e, 1'b0, sh_e, al_e, s8, s5};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {err_o, w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop, sximm8, sximm5};
    endfunction

    function automatic logic [W-1:0] idle(input logic [15:0] s8, input logic [15:0] s5);
        return cv(1'b1, 3'd0, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, s8, s5);
    endfunction

    function automatic logic [W-1:0] dec_st(input logic [15:0] s8, input logic [15:0] s5);
        return cv(1'b0, 3'd0, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, s8, s5);
    endfunction

    // scoreboard check
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_next(input string tag);
        if (exp_q.size() == 0) check({tag, " underflow"}, '0, '1);
        else                   check(tag, obs_vec(), exp_q.pop_front());
    endtask

    // driver: load+start together, then compare n cycles against the queue
    task automatic run_instr(input string tag, input logic [15:0] word, input int n,
                             input logic hold_s, input logic noise);
        in   = word;
        load = 1'b1;
        s    = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check_next($sformatf("%s c%0d", tag, i));
            if (i == n) begin
                s    = 1'b0;
                load = 1'b0;
            end else begin
                s    = hold_s;
                load = noise;
                in   = noise ? 16'hFFFF : word;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in    = 16'h0000;
        load  = 1'b0;
        s     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", obs_vec(), idle(16'h0000, 16'h0000));
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", obs_vec(), idle(16'h0000, 16'h0000));

        // MOV R0,#7
        exp_q.push_back(dec_st(16'h0007, 16'h0007));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 1, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 0, 16'h0007, 16'h0007));
        exp_q.push_back(idle(16'h0007, 16'h0007));
        run_instr("mov_imm7", 16'hD007, 3, 1'b0, 1'b0);

        // MOV R1,#-2 with load noise outside WAIT
        exp_q.push_back(dec_st(16'hFFFE, 16'hFFFE));
        exp_q.push_back(cv(0, 3'd0, 3'd1, 1, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 0, 16'hFFFE, 16'hFFFE));
        exp_q.push_back(idle(16'hFFFE, 16'hFFFE));
        run_instr("mov_imm_neg", 16'hD1FE, 3, 1'b0, 1'b1);

        // ADD R2,R1,R0,LSL#1
        exp_q.push_back(dec_st(16'h0048, 16'h0008));
        exp_q.push_back(cv(0, 3'd1, 3'd0, 0, 4'b0000, 4'b1000, 0, 2'b00, 2'b00, 0, 16'h0048, 16'h0008));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0100, 0, 2'b00, 2'b00, 0, 16'h0048, 16'h0008));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0010, 0, 2'b01, 2'b00, 0, 16'h0048, 16'h0008));
        exp_q.push_back(cv(0, 3'd0, 3'd2, 1, 4'b0001, 4'b0000, 0, 2'b00, 2'b00, 0, 16'h0048, 16'h0008));
        exp_q.push_back(idle(16'h0048, 16'h0008));
        run_instr("add", 16'hA148, 6, 1'b0, 1'b0);

        // CMP R1,R0
        exp_q.push_back(dec_st(16'h0000, 16'h0000));
        exp_q.push_back(cv(0, 3'd1, 3'd0, 0, 4'b0000, 4'b1000, 0, 2'b00, 2'b00, 0, 16'h0000, 16'h0000));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0100, 0, 2'b00, 2'b00, 0, 16'h0000, 16'h0000));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0001, 0, 2'b00, 2'b01, 0, 16'h0000, 16'h0000));
        exp_q.push_back(idle(16'h0000, 16'h0000));
        run_instr("cmp", 16'hA900, 5, 1'b0, 1'b0);

        // AND R3,R2,R1,LSR
        exp_q.push_back(dec_st(16'h0071, 16'hFFF1));
        exp_q.push_back(cv(0, 3'd2, 3'd0, 0, 4'b0000, 4'b1000, 0, 2'b00, 2'b00, 0, 16'h0071, 16'hFFF1));
        exp_q.push_back(cv(0, 3'd1, 3'd0, 0, 4'b0000, 4'b0100, 0, 2'b00, 2'b00, 0, 16'h0071, 16'hFFF1));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0010, 0, 2'b10, 2'b10, 0, 16'h0071, 16'hFFF1));
        exp_q.push_back(cv(0, 3'd0, 3'd3, 1, 4'b0001, 4'b0000, 0, 2'b00, 2'b00, 0, 16'h0071, 16'hFFF1));
        exp_q.push_back(idle(16'h0071, 16'hFFF1));
        run_instr("and", 16'hB271, 6, 1'b0, 1'b0);

        // MVN R5,R6,ASR
        exp_q.push_back(dec_st(16'hFFBE, 16'hFFFE));
        exp_q.push_back(cv(0, 3'd6, 3'd0, 0, 4'b0000, 4'b0100, 0, 2'b00, 2'b00, 0, 16'hFFBE, 16'hFFFE));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0010, 0, 2'b11, 2'b11, 0, 16'hFFBE, 16'hFFFE));
        exp_q.push_back(cv(0, 3'd0, 3'd5, 1, 4'b0001, 4'b0000, 0, 2'b00, 2'b00, 0, 16'hFFBE, 16'hFFFE));
        exp_q.push_back(idle(16'hFFBE, 16'hFFFE));
        run_instr("mvn", 16'hB8BE, 5, 1'b0, 1'b0);

        // MOV R4,R3,LSL#1
        exp_q.push_back(dec_st(16'hFF8B, 16'h000B));
        exp_q.push_back(cv(0, 3'd3, 3'd0, 0, 4'b0000, 4'b0100, 0, 2'b00, 2'b00, 0, 16'hFF8B, 16'h000B));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0010, 1, 2'b01, 2'b00, 0, 16'hFF8B, 16'h000B));
        exp_q.push_back(cv(0, 3'd0, 3'd4, 1, 4'b0001, 4'b0000, 0, 2'b00, 2'b00, 0, 16'hFF8B, 16'h000B));
        exp_q.push_back(idle(16'hFF8B, 16'hFFFF & 16'h000B));
        run_instr("mov_reg", 16'hC08B, 5, 1'b0, 1'b0);

        // back-to-back: s held high runs MOV R0,#7 twice
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(dec_st(16'h0007, 16'h0007));
            exp_q.push_back(cv(0, 3'd0, 3'd0, 1, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 0, 16'h0007, 16'h0007));
            exp_q.push_back(idle(16'h0007, 16'h0007));
        end
        run_instr("b2b", 16'hD007, 6, 1'b1, 1'b0);

        // reset during GET_B of ADD, with load/s also high in the reset cycle
        exp_q.push_back(dec_st(16'h0048, 16'h0008));
        exp_q.push_back(cv(0, 3'd1, 3'd0, 0, 4'b0000, 4'b1000, 0, 2'b00, 2'b00, 0, 16'h0048, 16'h0008));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0100, 0, 2'b00, 2'b00, 0, 16'h0048, 16'h0008));
        run_instr("add_abort", 16'hA148, 3, 1'b0, 1'b0);
        reset = 1'b1;
        in    = 16'hD1FE;
        load  = 1'b1;
        s     = 1'b1;
        @(negedge clk);
        check("abort reset", obs_vec(), idle(16'h0000, 16'h0000));
        reset = 1'b0;
        load  = 1'b0;
        s     = 1'b0;
        @(negedge clk);
        check("abort idle", obs_vec(), idle(16'h0000, 16'h0000));
        exp_q.push_back(dec_st(16'hFFFE, 16'hFFFE));
        exp_q.push_back(cv(0, 3'd0, 3'd1, 1, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 0, 16'hFFFE, 16'hFFFE));
        exp_q.push_back(idle(16'hFFFE, 16'hFFFE));
        run_instr("after_abort", 16'hD1FE, 3, 1'b0, 1'b0);

        // illegal opcode 111
`ifdef INSTR_CONTROLLER_ILLEGAL_TRAP_EN
        exp_q.push_back(dec_st(16'h0000, 16'h0000));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0000, 0, 2'b00, 2'b00, 1, 16'h0000, 16'h0000));
        run_instr("illegal", 16'hE000, 2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in   = 16'hD0FF;
            load = 1'b1;
            s    = 1'b1;
            @(negedge clk);
            check($sformatf("halt hold %0d", k), obs_vec(),
                  cv(0, 3'd0, 3'd0, 0, 4'b0000, 4'b0000, 0, 2'b00, 2'b00, 1, 16'h0000, 16'h0000));
        end
        load  = 1'b0;
        s     = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("halt reset", obs_vec(), idle(16'h0000, 16'h0000));
        reset = 1'b0;
`else
        exp_q.push_back(dec_st(16'h0000, 16'h0000));
        exp_q.push_back(idle(16'h0000, 16'h0000));
        run_instr("illegal", 16'hE000, 2, 1'b0, 1'b0);
`endif
        exp_q.push_back(dec_st(16'h0007, 16'h0007));
        exp_q.push_back(cv(0, 3'd0, 3'd0, 1, 4'b0100, 4'b0000, 0, 2'b00, 2'b00, 0, 16'h0007, 16'h0007));
        exp_q.push_back(idle(16'h0007, 16'h0007));
        run_instr("after_illegal", 16'hD007, 3, 1'b0, 1'b0);

        // final report
        if (exp_q.size() != 0) check("queue drained", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
